// File: rtl/gsim_pkg.sv
// Shared constants and width helper for the Gauss-Seidel stencil PE.
package gsim_pkg;

  localparam int GSIM_DIVISOR = 20;
  localparam int GSIM_C_NEAR  = 1;
  localparam int GSIM_C_MID   = -6;
  localparam int GSIM_C_FAR   = 13;

  // Stencil terms span at most 20*2^dw; add the shifted b term on top of that.
  function automatic int unsigned gsim_sum_w(input int unsigned dw, input int unsigned bw,
                                             input int unsigned frac);
    if (bw + frac > dw + 6) begin
      return bw + frac + 2;
    end
    return dw + 7;
  endfunction

endpackage

// File: rtl/gsim_div20.sv
// Combinational signed floor division by 20, exact over the full input range.
module gsim_div20
  import gsim_pkg::*;
#(
  parameter int unsigned W = 39
) (
  input  logic signed [W-1:0] num,
  output logic signed [W-1:0] quo
);

  localparam logic signed [W-1:0] Divisor = W'(GSIM_DIVISOR);

  logic signed [W-1:0] q_trunc;
  logic signed [W-1:0] r_trunc;

  always_comb begin
    q_trunc = num / Divisor;
    r_trunc = num % Divisor;
    // Truncating divide rounds toward zero; a negative remainder means one step down.
    quo     = q_trunc - W'(r_trunc[W-1]);
  end

endmodule

// File: rtl/gsim_pe_pipe.sv
// Three-stage handshaked Gauss-Seidel stencil PE with sideband tag.
// Define GSIM_PE_SAT_EN to clamp y to the DW range and flag clipping on sat.
module gsim_pe_pipe
  import gsim_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = 16,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    x1,
  input  logic signed [DW-1:0]    x2,
  input  logic signed [DW-1:0]    x3,
  input  logic signed [DW-1:0]    x4,
  input  logic signed [DW-1:0]    x5,
  input  logic signed [DW-1:0]    x6,
  input  logic signed [BW-1:0]    b,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    y,
  output logic        [TAG_W-1:0] out_tag,
  output logic                    sat
);

  localparam int unsigned SW = gsim_sum_w(DW, BW, FRAC);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 operands
  logic signed [DW:0]   a_d, c_d, d_d;
  logic signed [SW-1:0] b_ext, b_s_d;

  always_comb begin
    a_d   = {x1[DW-1], x1} + {x2[DW-1], x2};
    c_d   = {x3[DW-1], x3} + {x4[DW-1], x4};
    d_d   = {x5[DW-1], x5} + {x6[DW-1], x6};
    b_ext = {{(SW-BW){b[BW-1]}}, b};
    b_s_d = b_ext <<< FRAC;
  end

  logic                 s1_valid;
  logic signed [DW:0]   s1_a, s1_c, s1_d;
  logic signed [SW-1:0] s1_b;
  logic [TAG_W-1:0]     s1_tag;

  // S2 weighted sum, shift-add only
  logic signed [SW-1:0] a_e, c_e, d_e, sum_d;

  always_comb begin
    a_e   = {{(SW-DW-1){s1_a[DW]}}, s1_a};
    c_e   = {{(SW-DW-1){s1_c[DW]}}, s1_c};
    d_e   = {{(SW-DW-1){s1_d[DW]}}, s1_d};
    sum_d = s1_b + a_e - ((c_e <<< 2) + (c_e <<< 1)) + ((d_e <<< 3) + (d_e <<< 2) + d_e);
  end

  logic                 s2_valid;
  logic signed [SW-1:0] s2_sum;
  logic [TAG_W-1:0]     s2_tag;

  // S3 divide and narrow
  logic signed [SW-1:0] quo;
  logic signed [DW-1:0] y_d;
  logic                 sat_d;

  gsim_div20 #(
    .W(SW)
  ) u_div (
    .num(s2_sum),
    .quo(quo)
  );

`ifdef GSIM_PE_SAT_EN
  logic ovf;
  always_comb begin
    ovf   = (quo[SW-1:DW-1] != {(SW-DW+1){quo[SW-1]}});
    sat_d = ovf;
    y_d   = quo[DW-1:0];
    if (ovf) begin
      y_d = quo[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic unused_quo;
  assign unused_quo = ^quo[SW-1:DW];
  assign y_d        = quo[DW-1:0];
  assign sat_d      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_c      <= '0;
      s1_d      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_sum    <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      out_tag   <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_a      <= a_d;
      s1_c      <= c_d;
      s1_d      <= d_d;
      s1_b      <= b_s_d;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_sum    <= sum_d;
      s2_tag    <= s1_tag;
      out_valid <= s2_valid;
      y         <= y_d;
      out_tag   <= s2_tag;
      sat       <= sat_d;
    end
  end

endmodule
